// File: rtl/mips_mdu_pkg.sv
// Shared op codes, latency defaults and op-family helpers for the MIPS multiply/divide unit.
// Optional multiply-accumulate ops are enabled by defining MIPS_MDU_MADD_EN.
package mips_mdu_pkg;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  localparam logic [3:0] MDU_OP_NONE  = 4'd0;
  localparam logic [3:0] MDU_OP_MULT  = 4'd1;
  localparam logic [3:0] MDU_OP_MULTU = 4'd2;
  localparam logic [3:0] MDU_OP_DIV   = 4'd3;
  localparam logic [3:0] MDU_OP_DIVU  = 4'd4;
  localparam logic [3:0] MDU_OP_MTHI  = 4'd5;
  localparam logic [3:0] MDU_OP_MTLO  = 4'd6;
  localparam logic [3:0] MDU_OP_MADD  = 4'd7;
  localparam logic [3:0] MDU_OP_MADDU = 4'd8;
  localparam logic [3:0] MDU_OP_MSUB  = 4'd9;
  localparam logic [3:0] MDU_OP_MSUBU = 4'd10;

  typedef enum logic {ST_IDLE, ST_RUN} mdu_state_t;

  // How the pending 64-bit result is folded into {hi,lo} at commit.
  typedef enum logic [1:0] {CM_WRITE, CM_KEEP, CM_ADD, CM_SUB} mdu_commit_t;

  function automatic logic is_madd(input logic [3:0] op);
`ifdef MIPS_MDU_MADD_EN
    return (op == MDU_OP_MADD) || (op == MDU_OP_MADDU) ||
           (op == MDU_OP_MSUB) || (op == MDU_OP_MSUBU);
`else
    return (op == 4'hF) && (op != 4'hF);
`endif
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) || is_div(op) || is_madd(op);
  endfunction

endpackage

// File: rtl/mips_mdu_calc.sv
// Combinational product/quotient datapath: returns {hi,lo}-shaped 64-bit result and a div-by-zero flag.
// No state, zero latency; the top samples the result only on accept.
module mips_mdu_calc
  import mips_mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result,
  output logic        o_div0
);

  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic        w_bzero;
  logic        w_ovf;
  logic [31:0] w_sb_safe;
  logic [31:0] w_ub_safe;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  assign w_smul  = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_umul  = {32'd0, i_a} * {32'd0, i_b};
  assign w_bzero = (i_b == 32'd0);
  assign w_ovf   = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  // Divisors are forced to 1 in the zero and overflow cases so the divider never sees them.
  assign w_sb_safe = (w_bzero || w_ovf) ? 32'd1 : i_b;
  assign w_ub_safe = w_bzero ? 32'd1 : i_b;

  assign w_sq = w_ovf ? 32'h8000_0000 : 32'($signed(i_a) / $signed(w_sb_safe));
  assign w_sr = w_ovf ? 32'd0         : 32'($signed(i_a) % $signed(w_sb_safe));
  assign w_uq = i_a / w_ub_safe;
  assign w_ur = i_a % w_ub_safe;

  always_comb begin
    o_result = 64'd0;
    case (i_op)
      MDU_OP_MULT, MDU_OP_MADD, MDU_OP_MSUB:    o_result = w_smul;
      MDU_OP_MULTU, MDU_OP_MADDU, MDU_OP_MSUBU: o_result = w_umul;
      MDU_OP_DIV:                               o_result = {w_sr, w_sq};
      MDU_OP_DIVU:                              o_result = {w_ur, w_uq};
      default:                                  o_result = 64'd0;
    endcase
  end

  assign o_div0 = is_div(i_op) && w_bzero;

endmodule

// File: rtl/mips_mdu.sv
// MIPS multiply/divide unit: owns HI/LO, runs mul/div for a fixed latency, pulses done at commit.
// Macro MIPS_MDU_MADD_EN adds madd/maddu/msub/msubu accumulate ops.
module mips_mdu
  import mips_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = 16;

  mdu_state_t  r_state;
  mdu_state_t  w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0] r_pend;
  mdu_commit_t r_mode;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [63:0] w_result;
  logic        w_div0;
  logic        w_idle;
  logic        w_accept;
  logic        w_commit;
  mdu_commit_t w_mode;

  mips_mdu_calc u_calc (
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_result (w_result),
    .o_div0   (w_div0)
  );

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = start && w_idle && is_muldiv(op);
  assign w_commit = (r_state == ST_RUN) && (r_cnt == '0);

  always_comb begin
    w_mode = CM_WRITE;
    if (w_div0)
      w_mode = CM_KEEP;
    else if ((op == MDU_OP_MADD) || (op == MDU_OP_MADDU))
      w_mode = CM_ADD;
    else if ((op == MDU_OP_MSUB) || (op == MDU_OP_MSUBU))
      w_mode = CM_SUB;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_commit) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_pend <= 64'd0;
      r_mode <= CM_WRITE;
      r_done <= 1'b0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_pend <= w_result;
        r_mode <= w_mode;
        r_cnt  <= is_div(op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
      end else if (r_state == ST_RUN) begin
        if (w_commit) begin
          r_done <= 1'b1;
          case (r_mode)
            CM_WRITE: {r_hi, r_lo} <= r_pend;
            CM_ADD:   {r_hi, r_lo} <= {r_hi, r_lo} + r_pend;
            CM_SUB:   {r_hi, r_lo} <= {r_hi, r_lo} - r_pend;
            default:  ;
          endcase
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end else if (start && w_idle) begin
        if (op == MDU_OP_MTHI) r_hi <= a;
        if (op == MDU_OP_MTLO) r_lo <= a;
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state == ST_RUN);
  assign done = r_done;

endmodule

// File: tb/tb_mips_mdu.sv
// Directed plus randomized bench for mips_mdu against a plain-arithmetic HI/LO model.
// Define MIPS_MDU_MADD_EN to also exercise the accumulate ops.
module tb_mips_mdu;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_hl;

  mips_mdu #(.MULT_CYCLES(MULT_CYC), .DIV_CYCLES(DIV_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit is_acc(input logic [3:0] o);
`ifdef MIPS_MDU_MADD_EN
    return (o >= 4'd7) && (o <= 4'd10);
`else
    return 1'b0;
`endif
  endfunction

  // Reference: what {hi,lo} becomes when op o with operands va/vb finishes, given {hi,lo}=cur.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                                        input logic [63:0] cur);
    int sa, sb;
    longint la, lb, q, r;
    logic [63:0] ua, ub, sp, up, qv, rv;
    sa = va; sb = vb; la = sa; lb = sb;
    ua = {32'd0, va}; ub = {32'd0, vb};
    sp = la * lb;
    up = ua * ub;
    case (o)
      4'd1: return sp;
      4'd2: return up;
      4'd3: begin
        if (vb == 0) return cur;
        q = la / lb; r = la % lb; qv = q; rv = r;
        return {rv[31:0], qv[31:0]};
      end
      4'd4: begin
        if (vb == 0) return cur;
        qv = ua / ub; rv = ua % ub;
        return {rv[31:0], qv[31:0]};
      end
      4'd7:  return cur + sp;
      4'd8:  return cur + up;
      4'd9:  return cur - sp;
      4'd10: return cur - up;
      default: return cur;
    endcase
  endfunction

  task automatic run_md(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb, input bit inject);
    int lat;
    logic [63:0] nxt;
    lat = (o == 4'd3 || o == 4'd4) ? DIV_CYC : MULT_CYC;
    nxt = model(o, va, vb, exp_hl);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    for (int k = 1; k <= lat; k++) begin
      chk("busy_run", {63'd0, busy}, 64'd1);
      chk("hilo_hold", {hi, lo}, exp_hl);
      chk("done_early", {63'd0, done}, 64'd0);
      if (inject && k == 2) begin
        start = 1'b1; op = 4'd3; a = $urandom; b = $urandom | 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_hl = nxt;
    chk("busy_fall", {63'd0, busy}, 64'd0);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("hilo_commit", {hi, lo}, exp_hl);
    @(negedge clk);
    chk("done_clear", {63'd0, done}, 64'd0);
    chk("busy_idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_mt(input logic [3:0] o, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1; op = o; a = v; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (o == 4'd5) exp_hl[63:32] = v;
    else           exp_hl[31:0]  = v;
    chk("mt_hilo", {hi, lo}, exp_hl);
    chk("mt_busy", {63'd0, busy}, 64'd0);
    chk("mt_done", {63'd0, done}, 64'd0);
  endtask

  task automatic run_none(input logic [3:0] o);
    @(negedge clk);
    start = 1'b1; op = o; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("none_busy", {63'd0, busy}, 64'd0);
      chk("none_done", {63'd0, done}, 64'd0);
      chk("none_hilo", {hi, lo}, exp_hl);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    exp_hl = 64'd0;
    #23;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_md(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("tp_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_md(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("tp_multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_md(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("tp_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_mt(4'd5, 32'h11);
    run_mt(4'd6, 32'h22);
    run_md(4'd4, 32'd7, 32'd0, 1'b0);
    chk("tp_divu0", {hi, lo}, 64'h0000_0011_0000_0022);
    run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("tp_div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    run_md(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
    chk("tp_div_neg", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    run_md(4'd1, 32'h0001_2345, 32'hFFFF_0003, 1'b1);
    run_mt(4'd5, 32'hDEAD_BEEF);
    chk("tp_mthi", {32'd0, hi}, 64'h0000_0000_DEAD_BEEF);
    run_none(4'd0);
    run_none(4'd13);

`ifdef MIPS_MDU_MADD_EN
    run_mt(4'd5, 32'd0);
    run_mt(4'd6, 32'hFFFF_FFFF);
    run_md(4'd8, 32'd1, 32'd1, 1'b0);
    chk("tp_maddu", {hi, lo}, 64'h0000_0001_0000_0000);
    run_md(4'd7, 32'hFFFF_FFFF, 32'd3, 1'b0);
    run_md(4'd9, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    run_md(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`else
    run_mt(4'd5, 32'd0);
    run_mt(4'd6, 32'hFFFF_FFFF);
    run_none(4'd8);
    chk("tp_maddu_off", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    run_none(4'd7);
    run_none(4'd9);
    run_none(4'd10);
`endif

    for (int i = 0; i < 24; i++) begin
      ro = 4'($urandom_range(1, 10));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (ro == 4'd5 || ro == 4'd6) run_mt(ro, ra);
      else if (ro <= 4'd4 || is_acc(ro)) run_md(ro, ra, rb, ($urandom_range(0, 3) == 0));
      else run_none(ro);
    end

    run_md(4'd2, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 4'd1; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    exp_hl = 64'd0;
    chk("arst_hilo", {hi, lo}, exp_hl);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    #3 reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("arst_nodone", {63'd0, done}, 64'd0);
      chk("arst_idle", {63'd0, busy}, 64'd0);
    end
    chk("arst_hilo_after", {hi, lo}, exp_hl);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mdu.md
Name: mips_mdu

Overview:
- Multiply/divide unit for the MIPS datapath.
- Sits directly downstream of the register file:
  - consumes the two register-file read values (rs, rt) as operands;
  - holds the architectural HI/LO registers.
- mfhi/mflo results return to the register file via the existing writeback mux.
- Models multi-cycle latency with a busy flag so the control unit can stall later HI/LO users.

Parameters:
- MULT_CYCLES, 5, cycles from accepted mult/multu/madd-family op to HI/LO commit (must be >=1).
- DIV_CYCLES, 10, cycles from accepted div/divu op to HI/LO commit (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request strobe; op/a/b valid with it.
- op  input  4  operation code (encoding in Behaviour).
- a  input  32  operand from register-file read port 1 (rs).
- b  input  32  operand from register-file read port 2 (rt).
- hi  output  32  committed HI register.
- lo  output  32  committed LO register.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse on the edge HI/LO commit from an in-flight op.

Behaviour:
- Clock is clk; reset is asynchronous, active-high, named reset.
  - Reset asserted at any time, including mid-operation, immediately clears hi, lo, busy, done, counter, pending result and state to 0/IDLE.
  - The in-flight op is discarded.
- op encoding:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO;
  - 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU (optional feature only);
  - all other codes are NONE.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- Accept rule: start is honoured only in IDLE. start while RUN is ignored; control is required to stall, and the bench checks nothing changes.
- MULT/MULTU accepted at edge T:
  - 64-bit product computed from a,b at T (signed / unsigned) and stored as pending;
  - counter=MULT_CYCLES-1; state RUN.
  - At edge T+MULT_CYCLES: {hi,lo} <= product, done=1 for one cycle, state IDLE, busy=0.
  - busy is high for exactly MULT_CYCLES cycles.
- DIV/DIVU: same timing with DIV_CYCLES.
  - lo=quotient, hi=remainder.
  - Signed ops truncate toward zero; remainder takes the sign of the dividend.
  - b==0: hi/lo retain previous values, but busy/done timing is unchanged.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO: in IDLE, hi (resp. lo) <= a on the next edge. No busy, no done.
- Operands are sampled only at accept. Later changes on a/b have no effect.
- hi/lo outputs always show committed values; pending results are never visible early.
- done is 0 except the single commit cycle. MTHI/MTLO never raise done.
- Stall contract for control: a HI/LO consumer must stall while (start && op is mul/div family) || busy.

Optional Feature:
- Macro: MIPS_MDU_MADD_EN.
- Defined:
  - ops 7-10 are accepted with MULT_CYCLES latency;
  - at commit {hi,lo} <= {hi,lo} ± product (signed for 7/9, unsigned for 8/10);
  - the value used is the {hi,lo} at commit time, with mod 2^64 wrap-around.
- Undefined: ops 7-10 decode as NONE (no state change, busy stays 0).

Decomposition:
- Shared package mips_mdu_pkg holds:
  - op code constants (MDU_OP_NONE … MDU_OP_MSUBU);
  - the op-family classification function (is_muldiv);
  - default latency constants.
- One natural sub-module: mips_mdu_calc, combinational.
  - Inputs: op, a, b.
  - Outputs: 64-bit result plus div-by-zero flag.
  - Instantiated once; the top holds the FSM, counter, pending register and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFF b=2 → busy high for 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE, done pulse once; MULTU same operands → hi=0x00000001 lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 → after 10 cycles lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=7 b=0 after MTHI 0x11/MTLO 0x22 → hi=0x11 lo=0x22 retained, done still pulses at cycle 10.
- MULT started, then start with DIV at busy cycle 2 → DIV ignored, MULT result commits at cycle 5, busy falls once.
- MULT started, reset pulsed asynchronously mid-cycle 3 → hi=lo=0, busy=0 immediately, no done thereafter.
- MTHI a=0xDEADBEEF in IDLE → hi=0xDEADBEEF next edge, busy and done stay 0; operands changed during a MULT run do not affect the result.
- With MIPS_MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU a=1 b=1 → hi=1 lo=0 after 5 cycles; without macro same op → no change, busy 0.
